pipe_control_unit: RTL
======================

PIPE_CONTROL_UNIT -- requirements
Module: pipe_control_unit

Interface
REQ-001 Parameter XLEN, 32, operand width for branch compare.
REQ-002 Parameter FLUSH_CYCLES, 1, wrong-path slots squashed after redirect (1..7).
REQ-003 clk  in  1  sole clock; all state on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 in_valid  in  1  decode-side instruction valid.
REQ-006 in_ready  out  1  unit accepts instruction this cycle.
REQ-007 opcode  in  7  instruction opcode.
REQ-008 optype  in  instruction_op_type  decoded format (common package).
REQ-009 funct3  in  3  branch/load sub-op.
REQ-010 rd_addr  in  5  destination register.
REQ-011 rs1_addr  in  5  source 1 register.
REQ-012 rs2_addr  in  5  source 2 register.
REQ-013 rs1_data  in  XLEN  source 1 value.
REQ-014 rs2_data  in  XLEN  source 2 value.
REQ-015 out_valid  out  1  registered control word valid.
REQ-016 out_ready  in  1  execute stage consumes control word.
REQ-017 ctrl_mem_write / ctrl_mem_read / ctrl_mem_to_reg  out  1 each  memory controls.
REQ-018 ctrl_reg_wr_en  out  1  register-file write enable.
REQ-019 ctrl_alu_src  out  1  ALU operand B = immediate.
REQ-020 ctrl_is_branch / ctrl_is_jump  out  1 each  instruction class.
REQ-021 ctrl_redirect  out  1  taken branch or jump; PC must redirect.
REQ-022 ctrl_illegal  out  1  unknown optype or branch funct3.
REQ-023 perf_redirect_cnt  out  32  count of issued redirects.

Function
REQ-024 Single registered stage: instruction accepted on in_valid&in_ready; control word appears next cycle with out_valid=1; latency 1.
REQ-025 Output hold: out_valid&!out_ready freezes all outputs and forces in_ready=0.
REQ-026 Decode per accepted instruction, all controls default 0 (no carry-over): R: reg_wr_en; I: reg_wr_en, alu_src, plus mem_read+mem_to_reg if LOAD/LOAD_FP; S: alu_src, mem_write; B: is_branch; U: reg_wr_en (LUI and AUIPC), alu_src; J: is_jump, redirect.
REQ-027 Branch compare: BEQ/BNE equality, BLT/BGE signed XLEN, BLTU/BGEU unsigned XLEN; taken sets ctrl_redirect.
REQ-028 Unknown optype or B funct3 in {2,3}: ctrl_illegal=1, all other controls 0, out_valid=1.
REQ-029 FSM states RUN, STALL, FLUSH.
REQ-030 RUN->STALL: held word has mem_read, rd_q!=0, and in_valid with rs1_addr or rs2_addr == rd_q; in_ready=0 one cycle; bubble (out_valid=0) issued when out_ready; returns to RUN.
REQ-031 RUN->FLUSH: when a word with ctrl_redirect is issued; counter loads FLUSH_CYCLES; in_ready=1; accepted instructions discarded (out_valid=0); counter decrements per accepted slot; at 0 -> RUN.
REQ-032 Redirect and load-use hazard same cycle: FLUSH wins; no stall.
REQ-033 rd_addr==0 never triggers STALL.
REQ-034 perf_redirect_cnt increments once per issued redirect word; wraps 0xFFFFFFFF->0.

Reset
REQ-035 rst_n low asynchronously forces RUN, flush counter 0, out_valid=0, all ctrl_* 0, perf_redirect_cnt 0, in_ready 0 while asserted; in-flight word discarded.
REQ-036 First accept possible on first rising clk after rst_n deasserts.

Configuration
REQ-037 Macro CTRL_PERF_CNT_EN: defined -> perf_redirect_cnt counts per REQ-034; undefined -> port present, tied 0, no counter flops.

Verification
REQ-038 ADD (R) then LW (I, LOAD) back-to-back, out_ready=1 -> cycle1 reg_wr_en=1; cycle2 reg_wr_en, alu_src, mem_read, mem_to_reg =1.
REQ-039 BLTU rs1=0xFFFFFFFF rs2=1 -> redirect=0; BLT same data -> redirect=1, next FLUSH_CYCLES accepted instructions give out_valid=0.
REQ-040 LW x5 then ADD x6,x5,x1 -> in_ready=0 one cycle, one bubble, ADD issued next; repeat with rd=x0 -> no stall.
REQ-041 out_ready=0 for 3 cycles with SW held -> outputs stable, in_ready=0, SW issued once on release.
REQ-042 rst_n low mid-FLUSH -> out_valid=0, counter 0 immediately; perf count 0; with CTRL_PERF_CNT_EN, 3 JALs -> perf_redirect_cnt=3.

Source files
------------

// File: rtl/pipe_control_unit_if.sv
// Decode-to-execute handshake bundle for pipe_control_unit.
// optype carries the instruction_op_type encoding from pipe_control_unit_pkg.
interface pipe_control_unit_if #(
    parameter int XLEN = 32
) ();
    logic            in_valid;
    logic            in_ready;
    logic [6:0]      opcode;
    logic [2:0]      optype;
    logic [2:0]      funct3;
    logic [4:0]      rd_addr;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;

    logic            out_valid;
    logic            out_ready;
    logic            ctrl_mem_write;
    logic            ctrl_mem_read;
    logic            ctrl_mem_to_reg;
    logic            ctrl_reg_wr_en;
    logic            ctrl_alu_src;
    logic            ctrl_is_branch;
    logic            ctrl_is_jump;
    logic            ctrl_redirect;
    logic            ctrl_illegal;
    logic [31:0]     perf_redirect_cnt;

    modport slave (
        input  in_valid, opcode, optype, funct3, rd_addr, rs1_addr, rs2_addr,
               rs1_data, rs2_data, out_ready,
        output in_ready, out_valid, ctrl_mem_write, ctrl_mem_read, ctrl_mem_to_reg,
               ctrl_reg_wr_en, ctrl_alu_src, ctrl_is_branch, ctrl_is_jump,
               ctrl_redirect, ctrl_illegal, perf_redirect_cnt
    );

    modport master (
        output in_valid, opcode, optype, funct3, rd_addr, rs1_addr, rs2_addr,
               rs1_data, rs2_data, out_ready,
        input  in_ready, out_valid, ctrl_mem_write, ctrl_mem_read, ctrl_mem_to_reg,
               ctrl_reg_wr_en, ctrl_alu_src, ctrl_is_branch, ctrl_is_jump,
               ctrl_redirect, ctrl_illegal, perf_redirect_cnt
    );
endinterface

// File: rtl/pipe_control_unit.sv
// Single-stage decode control unit with load-use stall and post-redirect flush.
// Optional macro CTRL_PERF_CNT_EN enables the redirect performance counter.
package pipe_control_unit_pkg;
    typedef enum logic [2:0] {
        R_TYPE = 3'd0,
        I_TYPE = 3'd1,
        S_TYPE = 3'd2,
        B_TYPE = 3'd3,
        U_TYPE = 3'd4,
        J_TYPE = 3'd5
    } instruction_op_type;

    typedef struct packed {
        logic mem_write;
        logic mem_read;
        logic mem_to_reg;
        logic reg_wr_en;
        logic alu_src;
        logic is_branch;
        logic is_jump;
        logic redirect;
        logic illegal;
    } ctrl_t;

    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_LOAD_FP = 7'b0000111;
endpackage

module pipe_control_unit
    import pipe_control_unit_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    pipe_control_unit_if.slave bus
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [2:0] FLUSH_LOAD       = 3'(FLUSH_CYCLES);
    localparam logic [2:0] FLUSH_AFTER_SLOT = 3'(FLUSH_CYCLES - 1);

    function automatic ctrl_t decode(
        input logic [2:0]      ot,
        input logic [6:0]      opc,
        input logic [2:0]      f3,
        input logic [XLEN-1:0] a,
        input logic [XLEN-1:0] b
    );
        ctrl_t              c;
        logic               taken;
        instruction_op_type op;
        c     = '0;
        taken = 1'b0;
        op    = instruction_op_type'(ot);
        case (op)
            R_TYPE: c.reg_wr_en = 1'b1;
            I_TYPE: begin
                c.reg_wr_en = 1'b1;
                c.alu_src   = 1'b1;
                if (opc == OPC_LOAD || opc == OPC_LOAD_FP) begin
                    c.mem_read   = 1'b1;
                    c.mem_to_reg = 1'b1;
                end
            end
            S_TYPE: begin
                c.alu_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            B_TYPE: begin
                case (f3)
                    3'd0:    taken = (a == b);
                    3'd1:    taken = (a != b);
                    3'd4:    taken = ($signed(a) <  $signed(b));
                    3'd5:    taken = ($signed(a) >= $signed(b));
                    3'd6:    taken = (a <  b);
                    3'd7:    taken = (a >= b);
                    default: c.illegal = 1'b1;
                endcase
                // An illegal branch reports only the illegal flag.
                if (!c.illegal) begin
                    c.is_branch = 1'b1;
                    c.redirect  = taken;
                end
            end
            U_TYPE: begin
                c.reg_wr_en = 1'b1;
                c.alu_src   = 1'b1;
            end
            J_TYPE: begin
                c.is_jump  = 1'b1;
                c.redirect = 1'b1;
            end
            default: c.illegal = 1'b1;
        endcase
        return c;
    endfunction

    state_t     state;
    logic [2:0] flush_cnt;
    logic       out_valid_q;
    ctrl_t      ctrl_q;
    logic [4:0] rd_q;

    logic  issue;
    logic  redirect_issue;
    logic  hazard;
    logic  in_ready_c;
    logic  accept;
    logic  squash;
    ctrl_t dec;

    always_comb begin
        issue          = out_valid_q & bus.out_ready;
        redirect_issue = issue & ctrl_q.redirect;
        // A held redirect pre-empts the load-use check: the flush covers the slot.
        hazard         = (state == RUN) & out_valid_q & ctrl_q.mem_read & ~ctrl_q.redirect
                       & (rd_q != 5'd0) & bus.in_valid
                       & ((bus.rs1_addr == rd_q) | (bus.rs2_addr == rd_q));
        in_ready_c     = rst_n & (~out_valid_q | bus.out_ready) & ~hazard;
        accept         = bus.in_valid & in_ready_c;
        // The slot accepted on the redirect's issue edge is already wrong-path.
        squash         = (state == FLUSH) | redirect_issue;
        dec            = decode(bus.optype, bus.opcode, bus.funct3, bus.rs1_data, bus.rs2_data);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            flush_cnt   <= '0;
            out_valid_q <= 1'b0;
            ctrl_q      <= '0;
            rd_q        <= '0;
        end else begin
            if (accept && !squash) begin
                out_valid_q <= 1'b1;
                ctrl_q      <= dec;
                rd_q        <= bus.rd_addr;
            end else if (issue) begin
                out_valid_q <= 1'b0;
                ctrl_q      <= '0;
                rd_q        <= '0;
            end

            case (state)
                RUN: begin
                    if (redirect_issue) begin
                        if (accept) begin
                            flush_cnt <= FLUSH_AFTER_SLOT;
                            state     <= (FLUSH_AFTER_SLOT == 3'd0) ? RUN : FLUSH;
                        end else begin
                            flush_cnt <= FLUSH_LOAD;
                            state     <= FLUSH;
                        end
                    end else if (hazard && bus.out_ready) begin
                        state <= STALL;
                    end
                end
                STALL: state <= RUN;
                FLUSH: begin
                    if (accept) begin
                        flush_cnt <= flush_cnt - 3'd1;
                        if (flush_cnt == 3'd1) state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    assign bus.in_ready        = in_ready_c;
    assign bus.out_valid       = out_valid_q;
    assign bus.ctrl_mem_write  = ctrl_q.mem_write;
    assign bus.ctrl_mem_read   = ctrl_q.mem_read;
    assign bus.ctrl_mem_to_reg = ctrl_q.mem_to_reg;
    assign bus.ctrl_reg_wr_en  = ctrl_q.reg_wr_en;
    assign bus.ctrl_alu_src    = ctrl_q.alu_src;
    assign bus.ctrl_is_branch  = ctrl_q.is_branch;
    assign bus.ctrl_is_jump    = ctrl_q.is_jump;
    assign bus.ctrl_redirect   = ctrl_q.redirect;
    assign bus.ctrl_illegal    = ctrl_q.illegal;

`ifdef CTRL_PERF_CNT_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else if (redirect_issue) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign bus.perf_redirect_cnt = perf_q;
`else
    assign bus.perf_redirect_cnt = '0;
`endif

endmodule
